// File: rtl/core_pkg.sv
// Core-wide widths shared by the writeback path.
package core_pkg;
    parameter int unsigned XLEN = 32;
    typedef logic [5:0] preg_tag_t;
endpackage

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding two PRF write ports, round-robin.
// Optional same-tag deferral counter enabled by defining WB_ARB_PERF_EN.
module wb_arbiter #(
    parameter int unsigned XLEN       = core_pkg::XLEN,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [NUM_SRC-1:0]  src_valid,
    output logic [NUM_SRC-1:0]  src_ready,
    input  core_pkg::preg_tag_t src_tag  [NUM_SRC],
    input  logic [XLEN-1:0]     src_data [NUM_SRC],
    output logic                wen0,
    output core_pkg::preg_tag_t wtag0,
    output logic [XLEN-1:0]     wdata0,
    output logic                wen1,
    output core_pkg::preg_tag_t wtag1,
    output logic [XLEN-1:0]     wdata1
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]         perf_conflict_cnt
`endif
);
    localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    typedef logic [SW-1:0] sidx_t;

    core_pkg::preg_tag_t tag_mem  [NUM_SRC][FIFO_DEPTH];
    logic [XLEN-1:0]     data_mem [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0]       head  [NUM_SRC];
    logic [PW-1:0]       tail  [NUM_SRC];
    logic [CW-1:0]       count [NUM_SRC];

    core_pkg::preg_tag_t head_tag  [NUM_SRC];
    logic [XLEN-1:0]     head_data [NUM_SRC];
    logic [NUM_SRC-1:0]  nonempty, enq, deq;
    sidx_t               rr_ptr, rr_next, scan_idx, last_idx, g0_idx, g1_idx;
    logic                g0, g1;
`ifdef WB_ARB_PERF_EN
    logic                conflict;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count[i] != CW'(FIFO_DEPTH));
            nonempty[i]  = (count[i] != '0);
            enq[i]       = src_valid[i] & src_ready[i] & ~flush;
            head_tag[i]  = tag_mem[i][head[i]];
            head_data[i] = data_mem[i][head[i]];
        end
    end

    // Scan from rr_ptr; port 1 skips any head whose tag collides with port 0.
    always_comb begin
        g0       = 1'b0;
        g1       = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_idx = '0;
`ifdef WB_ARB_PERF_EN
        conflict = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx = sidx_t'((32'(rr_ptr) + k) % NUM_SRC);
            if (!flush && nonempty[scan_idx]) begin
                if (!g0) begin
                    g0     = 1'b1;
                    g0_idx = scan_idx;
                end else if (!g1) begin
                    if (head_tag[scan_idx] != head_tag[g0_idx]) begin
                        g1     = 1'b1;
                        g1_idx = scan_idx;
                    end else begin
`ifdef WB_ARB_PERF_EN
                        conflict = 1'b1;
`endif
                    end
                end
            end
        end
        last_idx = g1 ? g1_idx : g0_idx;
        rr_next  = rr_ptr;
        if (g0) begin
            rr_next = (last_idx == sidx_t'(NUM_SRC - 1)) ? '0 : last_idx + 1'b1;
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            deq[i] = (g0 && g0_idx == sidx_t'(i)) || (g1 && g1_idx == sidx_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (enq[i]) begin
                tag_mem[i][tail[i]]  <= src_tag[i];
                data_mem[i][tail[i]] <= src_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rr_ptr <= '0;
            wen0   <= 1'b0;
            wtag0  <= '0;
            wdata0 <= '0;
            wen1   <= 1'b0;
            wtag1  <= '0;
            wdata1 <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            wen0   <= g0;
            wtag0  <= g0 ? head_tag[g0_idx]  : '0;
            wdata0 <= g0 ? head_data[g0_idx] : '0;
            wen1   <= g1;
            wtag1  <= g1 ? head_tag[g1_idx]  : '0;
            wdata1 <= g1 ? head_data[g1_idx] : '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (enq[i]) tail[i] <= tail[i] + 1'b1;
                if (deq[i]) head[i] <= head[i] + 1'b1;
                case ({enq[i], deq[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    // Cleared by reset only; flush leaves the statistic intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
        end else if (conflict && perf_conflict_cnt != '1) begin
            perf_conflict_cnt <= perf_conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes queued at stimulus time, checked on output.
module tb_wb_arbiter;
    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                flush = 1'b0;
    logic [3:0]          src_valid = '0;
    logic [3:0]          src_ready;
    core_pkg::preg_tag_t src_tag  [4];
    logic [31:0]         src_data [4];
    logic                wen0, wen1;
    core_pkg::preg_tag_t wtag0, wtag1;
    logic [31:0]         wdata0, wdata1;
`ifdef WB_ARB_PERF_EN
    logic [31:0]         perf_conflict_cnt;
    logic [31:0]         perf_base;
`endif

    typedef struct {
        logic [5:0]  t0;
        logic [31:0] d0;
        logic        e1;
        logic [5:0]  t1;
        logic [31:0] d1;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_pass = 0;
    int  n_total = 0;
    logic mon_en = 1'b0;

    wb_arbiter #(.XLEN(32), .NUM_SRC(4), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_data(src_data),
        .wen0(wen0), .wtag0(wtag0), .wdata0(wdata0),
        .wen1(wen1), .wtag1(wtag1), .wdata1(wdata1)
`ifdef WB_ARB_PERF_EN
        , .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            n_total++;
            if (wen0 || wen1) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got wen0=%b wtag0=%0d wdata0=%h wen1=%b wtag1=%0d wdata1=%h, required no write",
                             wen0, wtag0, wdata0, wen1, wtag1, wdata1);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({wen0, wtag0, wdata0, wen1, wtag1, wdata1} !==
                        {1'b1, mon_e.t0, mon_e.d0, mon_e.e1, mon_e.t1, mon_e.d1})
                        $display("FAIL write_entry: got wen0=%b wtag0=%0d wdata0=%h wen1=%b wtag1=%0d wdata1=%h, required 1 %0d %h %b %0d %h",
                                 wen0, wtag0, wdata0, wen1, wtag1, wdata1,
                                 mon_e.t0, mon_e.d0, mon_e.e1, mon_e.t1, mon_e.d1);
                    else n_pass++;
                end
            end else begin
                if ({wtag0, wdata0, wtag1, wdata1} !== '0)
                    $display("FAIL idle_zero: got wtag0=%0d wdata0=%h wtag1=%0d wdata1=%h, required all 0",
                             wtag0, wdata0, wtag1, wdata1);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [5:0] tag, input logic [31:0] data);
        src_valid[i] = 1'b1;
        src_tag[i]   = tag;
        src_data[i]  = data;
    endtask

    task automatic expect_wr(input logic [5:0] t0, input logic [31:0] d0,
                             input logic e1, input logic [5:0] t1, input logic [31:0] d1);
        wr_t e;
        e.t0 = t0; e.d0 = d0; e.e1 = e1; e.t1 = t1; e.d1 = d1;
        exp_q.push_back(e);
    endtask

    task automatic do_flush();
        src_valid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        n_total++;
        if (exp_q.size() !== 0) begin
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src_valid = '0;
        for (int i = 0; i < 4; i++) begin
            src_tag[i]  = '0;
            src_data[i] = '0;
        end
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({wen0, wen1} !== 2'b00) $display("FAIL reset_wen: got %b, required 00", {wen0, wen1});
        else n_pass++;
        n_total++;
        if ({wtag0, wdata0, wtag1, wdata1} !== '0)
            $display("FAIL reset_wdata: got %0d %h %0d %h, required 0", wtag0, wdata0, wtag1, wdata1);
        else n_pass++;
        n_total++;
        if (src_ready !== 4'b1111) $display("FAIL reset_ready: got %b, required 1111", src_ready);
        else n_pass++;
`ifdef WB_ARB_PERF_EN
        n_total++;
        if (perf_conflict_cnt !== 32'd0) $display("FAIL reset_perf: got %0d, required 0", perf_conflict_cnt);
        else n_pass++;
`endif
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        drive(0, 6'd5, 32'hAA);
        expect_wr(6'd5, 32'hAA, 1'b0, '0, '0);
        tick();
        src_valid = '0;
        @(negedge clk);
        n_total++;
        if (wen0 !== 1'b0) $display("FAIL latency_early: got wen0=%b, required 0", wen0);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wen0 !== 1'b1) $display("FAIL latency_two: got wen0=%b, required 1", wen0);
        else n_pass++;
        drain("single");
    endtask

    // Back-to-back chain whose grant order depends on rr_ptr after each step.
    task automatic test_round_robin();
        do_flush();
        drive(0, 6'd3, 32'h11);
        drive(1, 6'd7, 32'h22);
        expect_wr(6'd3, 32'h11, 1'b1, 6'd7, 32'h22);
        tick();
        src_valid = '0;
        drive(1, 6'd10, 32'h0A);
        drive(2, 6'd11, 32'h0B);
        expect_wr(6'd11, 32'h0B, 1'b1, 6'd10, 32'h0A);
        tick();
        src_valid = '0;
        drive(2, 6'd12, 32'h0C);
        expect_wr(6'd12, 32'h0C, 1'b0, '0, '0);
        tick();
        for (int i = 0; i < 4; i++) drive(i, 6'(i + 1), 32'h41 + 32'(i));
        expect_wr(6'd4, 32'h44, 1'b1, 6'd1, 32'h41);
        expect_wr(6'd2, 32'h42, 1'b1, 6'd3, 32'h43);
        tick();
        src_valid = '0;
        drain("round_robin");
    endtask

    task automatic test_conflict();
        do_flush();
`ifdef WB_ARB_PERF_EN
        perf_base = perf_conflict_cnt;
`endif
        drive(1, 6'd9, 32'h51);
        drive(2, 6'd9, 32'h52);
        expect_wr(6'd9, 32'h51, 1'b0, '0, '0);
        expect_wr(6'd9, 32'h52, 1'b0, '0, '0);
        tick();
        src_valid = '0;
        drain("conflict");
`ifdef WB_ARB_PERF_EN
        n_total++;
        if (perf_conflict_cnt !== perf_base + 32'd1)
            $display("FAIL perf_conflict: got %0d, required %0d", perf_conflict_cnt, perf_base + 32'd1);
        else n_pass++;
        perf_base = perf_conflict_cnt;
`endif
    endtask

    task automatic test_backpressure();
        do_flush();
        drive(0, 6'd20, 32'h200);
        drive(1, 6'd21, 32'h210);
        drive(3, 6'd30, 32'h300);
        expect_wr(6'd20, 32'h200, 1'b1, 6'd21, 32'h210);
        expect_wr(6'd30, 32'h300, 1'b1, 6'd22, 32'h220);
        expect_wr(6'd23, 32'h230, 1'b1, 6'd31, 32'h310);
        expect_wr(6'd32, 32'h320, 1'b0, '0, '0);
        tick();
        n_total++;
        if (src_ready[3] !== 1'b1) $display("FAIL bp_ready_first: got %b, required 1", src_ready[3]);
        else n_pass++;
        drive(0, 6'd22, 32'h220);
        drive(1, 6'd23, 32'h230);
        drive(3, 6'd31, 32'h310);
        tick();
        n_total++;
        if (src_ready[3] !== 1'b0) $display("FAIL bp_ready_full: got %b, required 0", src_ready[3]);
        else n_pass++;
        src_valid = '0;
        drive(3, 6'd32, 32'h320);
        tick();
        n_total++;
        if (src_ready[3] !== 1'b1) $display("FAIL bp_ready_after_deq: got %b, required 1", src_ready[3]);
        else n_pass++;
        tick();
        src_valid = '0;
        drain("backpressure");
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 4; i++) drive(i, 6'(40 + i), 32'h400 + 32'(i));
        tick();
        src_valid = '0;
        drive(0, 6'd44, 32'h444);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        src_valid = '0;
        @(negedge clk);
        n_total++;
        if ({wen0, wen1} !== 2'b00) $display("FAIL flush_wen: got %b, required 00", {wen0, wen1});
        else n_pass++;
        n_total++;
        if (src_ready !== 4'b1111) $display("FAIL flush_ready: got %b, required 1111", src_ready);
        else n_pass++;
        drain("flush");
`ifdef WB_ARB_PERF_EN
        n_total++;
        if (perf_conflict_cnt !== perf_base)
            $display("FAIL flush_keeps_perf: got %0d, required %0d", perf_conflict_cnt, perf_base);
        else n_pass++;
`endif
    endtask

    task automatic test_mid_reset();
        drive(0, 6'd50, 32'h500);
        drive(1, 6'd51, 32'h510);
        tick();
        src_valid = '0;
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        n_total++;
        if (src_ready !== 4'b1111) $display("FAIL midreset_ready: got %b, required 1111", src_ready);
        else n_pass++;
        n_total++;
        if ({wen0, wen1} !== 2'b00) $display("FAIL midreset_wen: got %b, required 00", {wen0, wen1});
        else n_pass++;
`ifdef WB_ARB_PERF_EN
        n_total++;
        if (perf_conflict_cnt !== 32'd0) $display("FAIL midreset_perf: got %0d, required 0", perf_conflict_cnt);
        else n_pass++;
`endif
        drain("mid_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_conflict();
        test_backpressure();
        test_flush();
        test_mid_reset();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  XLEN, core_pkg::XLEN, result data width.
  NUM_SRC, 4, number of functional-unit result sources.
  FIFO_DEPTH, 2, entries per source queue (power of two, >=2).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk, input, 1, single clock; all state updates on rising edge.
  reset, input, 1, synchronous, active-high reset.
  flush, input, 1, pipeline flush; discards all queued results.
  src_valid, input, NUM_SRC, per-source result valid.
  src_ready, output, NUM_SRC, per-source queue can accept.
  src_tag, input, NUM_SRC x core_pkg::preg_tag_t, destination physical tag per source.
  src_data, input, NUM_SRC x XLEN, result data per source.
  wen0, output, 1, PRF write port 0 enable.
  wtag0, output, core_pkg::preg_tag_t, PRF write port 0 tag.
  wdata0, output, XLEN, PRF write port 0 data.
  wen1, output, 1, PRF write port 1 enable.
  wtag1, output, core_pkg::preg_tag_t, PRF write port 1 tag.
  wdata1, output, XLEN, PRF write port 1 data.
  perf_conflict_cnt, output, 32, same-tag deferral count (only with WB_ARB_PERF_EN).

Function
REQ-003 SHALL keep one FIFO of FIFO_DEPTH {tag,data} entries per source.
REQ-004 src_ready[i] SHALL be 1 iff FIFO i not full; it SHALL NOT depend on same-cycle dequeue.
REQ-005 Enqueue on src_valid[i] & src_ready[i]; src_valid while not ready SHALL be ignored (no overwrite).
REQ-006 Each cycle scan FIFO heads from index rr_ptr upward, wrapping modulo NUM_SRC; first non-empty head -> port 0 grant.
REQ-007 Continue scan; next non-empty head whose tag differs from port 0 tag -> port 1 grant; same-tag heads are skipped (deferred).
REQ-008 Port 1 SHALL be granted only if port 0 is granted; wen1 implies wen0.
REQ-009 Granted heads dequeue in the grant cycle; wen/wtag/wdata SHALL be registered, asserted the cycle after grant.
REQ-010 Minimum latency enqueue->wen SHALL be 2 cycles; no combinational input-to-output bypass.
REQ-011 rr_ptr SHALL advance to (index of last granted source + 1) mod NUM_SRC; unchanged when no grant.
REQ-012 When wen0/wen1 deasserted, wtag/wdata SHALL hold 0.
REQ-013 FIFO head/tail pointers SHALL wrap modulo FIFO_DEPTH; full/empty from occupancy count, full at FIFO_DEPTH.
REQ-014 Same-cycle enqueue and dequeue on one FIFO SHALL keep count unchanged and preserve order.
REQ-015 flush SHALL, on the next edge, empty all FIFOs, drop any same-cycle enqueue, set rr_ptr=0, deassert wen0/wen1; no grants in the flush cycle.
REQ-016 flush and reset asserted together: reset behaviour applies.

Reset
REQ-017 On reset edge: all FIFOs empty, rr_ptr=0, wen0=wen1=0, wtag0/1=0, wdata0/1=0, perf_conflict_cnt=0.
REQ-018 src_ready SHALL read all-ones in the cycle after reset deasserts.
REQ-019 Reset mid-operation SHALL discard queued results with no write emitted afterward.

Configuration
REQ-020 Macro WB_ARB_PERF_EN defined: perf_conflict_cnt present, +1 per cycle any head is skipped by REQ-007, saturating at 0xFFFFFFFF, cleared by reset only (not flush).
REQ-021 WB_ARB_PERF_EN undefined: perf_conflict_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-022 Reset, then src0 {tag 5, 0xAA} cycle 0 -> cycle 2: wen0=1, wtag0=5, wdata0=0xAA, wen1=0.
REQ-023 src0 {3,0x11}, src1 {7,0x22} same cycle, rr_ptr=0 -> two cycles later wen0/wtag0=3, wen1/wtag1=7; rr_ptr=2.
REQ-024 src1 and src2 both tag 9 same cycle -> first cycle only src1 written on port 0, src2 next cycle on port 0; perf_conflict_cnt=1 (macro on).
REQ-025 Hold src3 valid 3 cycles while other sources saturate ports with rr_ptr away from 3 -> src_ready[3]=0 after 2 accepts; third beat held, accepted after a dequeue, order preserved.
REQ-026 All four FIFOs hold 1 entry, flush asserted -> next cycle wen0=wen1=0, src_ready=4'b1111, no later writes of flushed tags.
REQ-027 Four single entries tags 1..4 with rr_ptr=3 -> grants order: (4,1) then (2,3).
